// File: rtl/template_scorer_pkg.sv
// Shared constants, score types and card codes for the corner template scorer.
// Also holds the template bit pattern that template_rom elaborates into constants.
package card_pkg;

    localparam int CORNER_WIDTH = 28;
    localparam int RANK_HEIGHT  = 40;
    localparam int SUIT_HEIGHT  = 29;
    localparam int RANK_SIZE    = CORNER_WIDTH * RANK_HEIGHT;
    localparam int SUIT_SIZE    = CORNER_WIDTH * SUIT_HEIGHT;
    localparam int ROM_DEPTH    = RANK_SIZE + SUIT_SIZE;
    localparam int ROM_AW       = $clog2(ROM_DEPTH);
    localparam int NUM_RANKS    = 13;
    localparam int NUM_SUITS    = 4;
    localparam int ROM_W        = NUM_RANKS;
    localparam int RANK_STEP    = 80;
    localparam int SUIT_STEP    = 200;

    typedef logic [10:0]       rank_score_t;
    typedef logic [9:0]        suit_score_t;
    typedef logic [ROM_AW-1:0] rom_addr_t;
    typedef logic [ROM_W-1:0]  rom_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RANK,
        ST_SUIT,
        ST_DRAIN,
        ST_DONE
    } scorer_state_t;

    // Comparator card codes: rank code = score index + 1, suit code = score index.
    typedef enum logic [3:0] {
        RANK_ACE = 4'd1, RANK_TWO, RANK_THREE, RANK_FOUR, RANK_FIVE, RANK_SIX,
        RANK_SEVEN, RANK_EIGHT, RANK_NINE, RANK_TEN, RANK_JACK, RANK_QUEEN, RANK_KING
    } rank_code_e;

    typedef enum logic [1:0] {
        SUIT_DIAMOND = 2'd0,
        SUIT_HEART   = 2'd1,
        SUIT_CLUB    = 2'd2,
        SUIT_SPADE   = 2'd3
    } suit_code_e;

    // Pixel travelling beside its ROM read, waiting for the template word.
    typedef struct packed {
        logic vld;
        logic suit;
        logic pix;
    } acc_stage_t;

    function automatic rank_code_e rank_code(input int idx);
        return rank_code_e'(4'(idx + 1));
    endfunction

    function automatic suit_code_e suit_code(input int idx);
        return suit_code_e'(2'(idx));
    endfunction

    // Rank template r is ink over its first 80*r pixels, suit template s over its first 200*s.
    function automatic rom_word_t template_word(input rom_addr_t addr);
        int        a;
        rom_word_t w;
        a = int'(addr);
        w = '0;
        if (a < RANK_SIZE) begin
            for (int r = 0; r < NUM_RANKS; r++) w[r] = (a < RANK_STEP * r);
        end else begin
            for (int s = 0; s < NUM_SUITS; s++) w[s] = ((a - RANK_SIZE) < SUIT_STEP * s);
        end
        return w;
    endfunction

endpackage

// File: rtl/template_scorer_rom.sv
// Template ROM: rank words at 0..RANK_SIZE-1, suit words (bits [3:0]) above.
// One-cycle synchronous read.
module template_rom
    import card_pkg::*;
(
    input  logic      clk,
    input  rom_addr_t addr,
    output rom_word_t data
);

    always_ff @(posedge clk) begin
        data <= template_word(addr);
    end

endmodule

// File: rtl/template_scorer.sv
// Streams one corner crop (rank rows then suit rows) and counts per-template mismatches.
// Define SCORER_LAST_CHECK_EN to flag pixel_last_in misplacement on err_out.
module template_scorer
    import card_pkg::*;
(
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             start_in,
    input  logic                             pixel_valid_in,
    input  logic                             pixel_in,
    input  logic                             pixel_last_in,
    output logic                             pixel_ready_out,
    output rank_score_t [NUM_RANKS-1:0]      rank_scores_out,
    output suit_score_t [NUM_SUITS-1:0]      suit_scores_out,
    output logic                             busy_out,
    output logic                             done_out,
    output logic                             err_out
);

    scorer_state_t state;
    rom_addr_t     idx;
    rom_addr_t     rom_addr;
    rom_word_t     rom_data;
    acc_stage_t    acc_q;
    logic          accept;
    logic          clear;

    assign accept   = pixel_valid_in && pixel_ready_out;
    assign clear    = start_in && (state == ST_IDLE);
    assign rom_addr = (state == ST_SUIT) ? rom_addr_t'(RANK_SIZE) + idx : idx;

    template_rom u_rom (
        .clk  (clk_in),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q <= '0;
        end else begin
            acc_q.vld  <= accept;
            acc_q.suit <= (state == ST_SUIT);
            acc_q.pix  <= pixel_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rank_scores_out <= '0;
            suit_scores_out <= '0;
        end else if (clear) begin
            rank_scores_out <= '0;
            suit_scores_out <= '0;
        end else if (acc_q.vld) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                if (!acc_q.suit)
                    rank_scores_out[r] <= rank_scores_out[r] + rank_score_t'(acc_q.pix ^ rom_data[r]);
            end
            for (int s = 0; s < NUM_SUITS; s++) begin
                if (acc_q.suit)
                    suit_scores_out[s] <= suit_scores_out[s] + suit_score_t'(acc_q.pix ^ rom_data[s]);
            end
        end
    end

`ifdef SCORER_LAST_CHECK_EN
    logic final_pix;
    assign final_pix = (state == ST_SUIT) && (idx == rom_addr_t'(SUIT_SIZE - 1));
`else
    logic unused_last;
    assign unused_last = pixel_last_in;
    assign err_out     = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_IDLE;
            idx             <= '0;
            pixel_ready_out <= 1'b0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
`ifdef SCORER_LAST_CHECK_EN
            err_out         <= 1'b0;
`endif
        end else begin
            done_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        state           <= ST_RANK;
                        idx             <= '0;
                        pixel_ready_out <= 1'b1;
                        busy_out        <= 1'b1;
                    end
                end
                ST_RANK: begin
                    if (accept) begin
                        if (idx == rom_addr_t'(RANK_SIZE - 1)) begin
                            idx   <= '0;
                            state <= ST_SUIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_SUIT: begin
                    if (accept) begin
                        if (idx == rom_addr_t'(SUIT_SIZE - 1)) begin
                            idx             <= '0;
                            state           <= ST_DRAIN;
                            pixel_ready_out <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                // The last suit pixel accumulates here; scores are final on entry to DONE.
                ST_DRAIN: begin
                    state    <= ST_DONE;
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
`ifdef SCORER_LAST_CHECK_EN
            if (clear)
                err_out <= 1'b0;
            else if (accept && (pixel_last_in != final_pix))
                err_out <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_template_scorer.sv
// Randomized directed bench for template_scorer against a pixel-array reference model.
module tb_template_scorer;
    import card_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pv = 1'b0;
    logic px = 1'b0;
    logic pl = 1'b0;
    logic ready, busy, done, err;
    rank_score_t [NUM_RANKS-1:0] rs;
    suit_score_t [NUM_SUITS-1:0] ss;

    int checks = 0;
    int errors = 0;
    bit pix [ROM_DEPTH];
    int exp_rank [NUM_RANKS];
    int exp_suit [NUM_SUITS];
    bit exp_err;
    bit aborted;

    template_scorer dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .start_in        (start),
        .pixel_valid_in  (pv),
        .pixel_in        (px),
        .pixel_last_in   (pl),
        .pixel_ready_out (ready),
        .rank_scores_out (rs),
        .suit_scores_out (ss),
        .busy_out        (busy),
        .done_out        (done),
        .err_out         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit exp_err_view(input bit e);
`ifdef SCORER_LAST_CHECK_EN
        return e;
`else
        return 1'b0 & e;
`endif
    endfunction

    // pmode: 0 all zero, 1 all ink, 2 random
    task automatic gen_pix(input int pmode);
        for (int i = 0; i < ROM_DEPTH; i++)
            pix[i] = (pmode == 0) ? 1'b0 : (pmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        // Model: a mismatch wherever the pixel differs from the template's ink run.
        for (int r = 0; r < NUM_RANKS; r++) begin
            exp_rank[r] = 0;
            for (int i = 0; i < RANK_SIZE; i++)
                if (pix[i] != (i < 80 * r)) exp_rank[r]++;
        end
        for (int s = 0; s < NUM_SUITS; s++) begin
            exp_suit[s] = 0;
            for (int j = 0; j < SUIT_SIZE; j++)
                if (pix[RANK_SIZE + j] != (j < 200 * s)) exp_suit[s]++;
        end
    endtask

    task automatic check_scores(input string tag);
        for (int r = 0; r < NUM_RANKS; r++)
            chk($sformatf("%s rank%0d", tag, r), 32'(rs[r]), exp_rank[r]);
        for (int s = 0; s < NUM_SUITS; s++)
            chk($sformatf("%s suit%0d", tag, s), 32'(ss[s]), exp_suit[s]);
    endtask

    // vmode: 0 continuous valid, 1 every other cycle, 2 random 3/4 duty
    task automatic run_pass(input string tag, input int vmode, input int start_at,
                            input int rst_at, input int last_at);
        int n, cyc, early;
        bit v, acc;
        n = 0; cyc = 0; early = 0; exp_err = 1'b0; aborted = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, " busy after start"}, 32'(busy), 1);
        chk({tag, " err cleared by start"}, 32'(err), 0);
        while (n < ROM_DEPTH && cyc < 20000) begin
            if (done) early++;
            if (n == rst_at) begin
                rst_n = 1'b0; pv = 1'b0;
                #1;
                chk({tag, " rst ready"}, 32'(ready), 0);
                chk({tag, " rst busy"}, 32'(busy), 0);
                chk({tag, " rst done"}, 32'(done), 0);
                chk({tag, " rst err"}, 32'(err), 0);
                chk({tag, " rst rank scores"}, 32'(rs == '0), 1);
                chk({tag, " rst suit scores"}, 32'(ss == '0), 1);
                aborted = 1'b1;
                break;
            end
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            pv = v; px = pix[n]; pl = (n == last_at); start = (n == start_at);
            acc = v && ready;
            if (acc && (pl != (n == ROM_DEPTH - 1))) exp_err = 1'b1;
            @(posedge clk);
            if (acc) n++;
            cyc++;
            @(negedge clk);
        end
        pv = 1'b0; pl = 1'b0; start = 1'b0;
        if (aborted) begin
            @(negedge clk); @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk({tag, " idle ready after rst"}, 32'(ready), 0);
            chk({tag, " idle busy after rst"}, 32'(busy), 0);
        end else begin
            chk({tag, " all pixels accepted"}, n, ROM_DEPTH);
            chk({tag, " no early done"}, early, 0);
            chk({tag, " done not at +1"}, 32'(done), 0);
            @(negedge clk);
            chk({tag, " done at +2"}, 32'(done), 1);
            chk({tag, " busy low at done"}, 32'(busy), 0);
            chk({tag, " err at done"}, 32'(err), 32'(exp_err_view(exp_err)));
            check_scores(tag);
            @(negedge clk);
            chk({tag, " done single cycle"}, 32'(done), 0);
            chk({tag, " err sticky"}, 32'(err), 32'(exp_err_view(exp_err)));
            chk({tag, " hold rank0"}, 32'(rs[0]), exp_rank[0]);
            chk({tag, " hold suit3"}, 32'(ss[3]), exp_suit[3]);
        end
    endtask

    initial begin
        #12;
        chk("reset ready", 32'(ready), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset err", 32'(err), 0);
        chk("reset rank scores", 32'(rs == '0), 1);
        chk("reset suit scores", 32'(ss == '0), 1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle ready", 32'(ready), 0);

        gen_pix(0);
        run_pass("zeros", 0, -1, -1, ROM_DEPTH - 1);
        chk("zeros king const", 32'(rs[12]), 960);
        chk("zeros spade const", 32'(ss[3]), 600);

        gen_pix(1);
        run_pass("ones", 0, -1, -1, ROM_DEPTH - 1);
        chk("ones ace const", 32'(rs[0]), 1120);
        chk("ones diamond const", 32'(ss[0]), 812);

        gen_pix(0);
        run_pass("zeros toggle", 1, -1, -1, ROM_DEPTH - 1);

        gen_pix(2);
        run_pass("random", 2, -1, -1, ROM_DEPTH - 1);

        gen_pix(0);
        run_pass("start midpass", 0, 500, -1, ROM_DEPTH - 1);

        gen_pix(2);
        run_pass("reset midpass", 2, -1, 800, ROM_DEPTH - 1);

        gen_pix(2);
        run_pass("last at 1000", 0, -1, -1, 1000);

        gen_pix(2);
        run_pass("clean after err", 2, -1, -1, ROM_DEPTH - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
